// File: rtl/turn_state_timer_if.sv
// rtl/turn_state_timer_if.sv - game-flow sequencer bus between move/checker logic and the sequencer
//
// Purpose: bundles the turn sequencer's control inputs and status outputs.
// Signals:
//   start        master->slave  begin a game from IDLE or an end state
//   move_valid   master->slave  1-cycle pulse, current player committed a legal move
//   win_detect   master->slave  board checker: last move completed a line
//   draw_detect  master->slave  board checker: board full, no line
//   state        slave->master  4-bit FSM state code
//   Timer        slave->master  remaining ticks in the current turn
//   player       slave->master  0 = P1, 1 = P2
//   move_accept  slave->master  1-cycle pulse, move registered
//   timeout      slave->master  1-cycle pulse, turn expired
interface turn_state_timer_if #(
    parameter int TIMER_W = 8
);
    logic               start;
    logic               move_valid;
    logic               win_detect;
    logic               draw_detect;
    logic [3:0]         state;
    logic [TIMER_W-1:0] Timer;
    logic               player;
    logic               move_accept;
    logic               timeout;

    modport master (
        output start, move_valid, win_detect, draw_detect,
        input  state, Timer, player, move_accept, timeout
    );

    modport slave (
        input  start, move_valid, win_detect, draw_detect,
        output state, Timer, player, move_accept, timeout
    );
endinterface

// File: rtl/turn_state_timer.sv
// rtl/turn_state_timer.sv - tic-tac-toe turn sequencer with prescaled per-turn countdown
//
// Purpose: tracks whose turn it is, counts down TURN_TIME prescaled ticks per turn,
// and sequences the check / win / draw states after each committed move.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of turn_state_timer_if (inputs start/move_valid/win_detect/
//          draw_detect; registered outputs state/Timer/player/move_accept/timeout)
// Configuration macro:
//   TURN_TIMEOUT_FORFEIT_EN  undefined: an expired turn passes to the opponent
//                            defined:   an expired turn forfeits the game to the opponent
module turn_state_timer #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int TIMER_W   = 8,
    parameter int TURN_TIME = 30
) (
    input  logic              clock,
    input  logic              reset,
    turn_state_timer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_P1_TURN = 4'd1,
        S_P2_TURN = 4'd2,
        S_CHECK1  = 4'd3,
        S_CHECK2  = 4'd4,
        S_P1_WIN  = 4'd5,
        S_P2_WIN  = 4'd6,
        S_DRAW    = 4'd7
    } state_e;

    // A 1-bit prescaler keeps CLK_DIV=1 legal; it then sits at 0 and ticks every cycle.
    localparam int                 PS_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0]    PS_MAX   = PS_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] TIME_MAX = TIMER_W'(TURN_TIME);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [PS_W-1:0]    ps_q, ps_d;
    logic               player_q, player_d;
    logic               move_accept_q, move_accept_d;
    logic               timeout_q, timeout_d;
    logic               tick;

    assign tick = (ps_q == PS_MAX);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        ps_d          = ps_q;
        player_d      = player_q;
        move_accept_d = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            S_IDLE, S_P1_WIN, S_P2_WIN, S_DRAW: begin
                if (bus.start) begin
                    state_d  = S_P1_TURN;
                    timer_d  = TIME_MAX;
                    player_d = 1'b0;
                    ps_d     = '0;
                end
            end

            S_P1_TURN, S_P2_TURN: begin
                ps_d = tick ? '0 : ps_q + PS_W'(1);
                // A committed move wins over an expiring tick on the same edge.
                if (bus.move_valid) begin
                    state_d       = (state_q == S_P1_TURN) ? S_CHECK1 : S_CHECK2;
                    move_accept_d = 1'b1;
                end else if (tick) begin
                    if (timer_q > TIMER_W'(1)) begin
                        timer_d = timer_q - TIMER_W'(1);
                    end else begin
                        timeout_d = 1'b1;
`ifdef TURN_TIMEOUT_FORFEIT_EN
                        state_d = (state_q == S_P1_TURN) ? S_P2_WIN : S_P1_WIN;
                        timer_d = '0;
`else
                        state_d  = (state_q == S_P1_TURN) ? S_P2_TURN : S_P1_TURN;
                        timer_d  = TIME_MAX;
                        player_d = ~player_q;
                        ps_d     = '0;
`endif
                    end
                end
            end

            S_CHECK1, S_CHECK2: begin
                if (bus.win_detect) begin
                    state_d = (state_q == S_CHECK1) ? S_P1_WIN : S_P2_WIN;
                end else if (bus.draw_detect) begin
                    state_d = S_DRAW;
                end else begin
                    state_d  = (state_q == S_CHECK1) ? S_P2_TURN : S_P1_TURN;
                    timer_d  = TIME_MAX;
                    player_d = ~player_q;
                    ps_d     = '0;
                end
            end

            // Unused codes recover to a clean IDLE.
            default: begin
                state_d  = S_IDLE;
                timer_d  = '0;
                player_d = 1'b0;
                ps_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            ps_q          <= '0;
            player_q      <= 1'b0;
            move_accept_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ps_q          <= ps_d;
            player_q      <= player_d;
            move_accept_q <= move_accept_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.Timer       = timer_q;
    assign bus.player      = player_q;
    assign bus.move_accept = move_accept_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_turn_state_timer.sv
// tb/tb_turn_state_timer.sv - self-checking bench for turn_state_timer
module tb_turn_state_timer;
    localparam int CLK_DIV   = 4;
    localparam int TIMER_W   = 8;
    localparam int TURN_TIME = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    turn_state_timer_if #(.TIMER_W(TIMER_W)) bus ();

    turn_state_timer #(
        .CLK_DIV  (CLK_DIV),
        .TIMER_W  (TIMER_W),
        .TURN_TIME(TURN_TIME)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic rst;
        logic st;
        logic mv;
        logic win;
        logic draw;
    } stim_t;

    typedef struct packed {
        logic [3:0] state;
        logic [7:0] timer;
        logic       player;
        logic       accept;
        logic       timeout;
    } obs_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Queue one cycle of stimulus together with the outputs expected after its edge.
    task automatic push(input logic rst, input logic st, input logic mv, input logic win,
                        input logic draw, input logic [3:0] s, input logic [7:0] t,
                        input logic p, input logic ma, input logic to);
        stim_q.push_back({rst, st, mv, win, draw});
        exp_q.push_back({s, t, p, ma, to});
    endtask

    task automatic drive_cycle(input stim_t s);
        reset            = s.rst;
        bus.start        = s.st;
        bus.move_valid   = s.mv;
        bus.win_detect   = s.win;
        bus.draw_detect  = s.draw;
        @(posedge clock);
        #1;
    endtask

    function automatic obs_t sample();
        return {bus.state, bus.Timer, bus.player, bus.move_accept, bus.timeout};
    endfunction

    task automatic test_reset;
        obs_t got, want;
        int   i = 0;
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front());
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %p want %p", i, got, want);
            end
            i++;
        end
    endtask

    task automatic test_start_countdown;
        obs_t got, want;
        int   i = 0;
        push(0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
        for (int k = 1; k <= 8; k++) push(0, 0, 0, 0, 0, 1, 8'(3 - k / 4), 0, 0, 0);
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front());
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL start_countdown[%0d]: got %p want %p", i, got, want);
            end
            i++;
        end
    endtask

    task automatic test_move_tick_collision;
        obs_t got, want;
        int   i = 0;
        for (int k = 0; k < 3; k++) push(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        push(0, 0, 1, 0, 0, 3, 1, 0, 1, 0);
        push(0, 1, 0, 0, 0, 2, 3, 1, 0, 0);
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front());
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL move_tick_collision[%0d]: got %p want %p", i, got, want);
            end
            i++;
        end
    endtask

    task automatic test_check_outcomes;
        obs_t got, want;
        int   i = 0;
        push(0, 0, 1, 0, 0, 4, 3, 1, 1, 0);
        push(0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        push(0, 0, 1, 0, 0, 3, 3, 0, 1, 0);
        push(0, 0, 0, 0, 1, 7, 3, 0, 0, 0);
        push(0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
        push(0, 0, 1, 0, 0, 3, 3, 0, 1, 0);
        push(0, 0, 0, 1, 1, 5, 3, 0, 0, 0);
        push(0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
        push(0, 0, 1, 0, 0, 3, 3, 0, 1, 0);
        push(0, 0, 0, 0, 0, 2, 3, 1, 0, 0);
        push(0, 0, 1, 0, 0, 4, 3, 1, 1, 0);
        push(0, 0, 0, 1, 0, 6, 3, 1, 0, 0);
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front());
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL check_outcomes[%0d]: got %p want %p", i, got, want);
            end
            i++;
        end
    endtask

    task automatic test_timeout;
        obs_t got, want;
        int   i = 0;
        push(0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
        for (int k = 1; k <= 11; k++) push(0, 0, 0, 0, 0, 1, 8'(3 - k / 4), 0, 0, 0);
`ifdef TURN_TIMEOUT_FORFEIT_EN
        push(0, 0, 0, 0, 0, 6, 0, 0, 0, 1);
        push(0, 0, 0, 0, 0, 6, 0, 0, 0, 0);
`else
        push(0, 0, 0, 0, 0, 2, 3, 1, 0, 1);
        push(0, 0, 0, 0, 0, 2, 3, 1, 0, 0);
`endif
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front());
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got %p want %p", i, got, want);
            end
            i++;
        end
    endtask

    task automatic test_ignored_inputs;
        obs_t got, want;
        int   i = 0;
`ifdef TURN_TIMEOUT_FORFEIT_EN
        push(0, 0, 1, 1, 1, 6, 0, 0, 0, 0);
`else
        push(0, 0, 0, 1, 1, 2, 3, 1, 0, 0);
`endif
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front());
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL ignored_inputs[%0d]: got %p want %p", i, got, want);
            end
            i++;
        end
    endtask

    task automatic test_reset_mid_game;
        obs_t got, want;
        int   i = 0;
`ifdef TURN_TIMEOUT_FORFEIT_EN
        push(0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
        push(0, 0, 1, 0, 0, 3, 3, 0, 1, 0);
        push(0, 0, 0, 0, 0, 2, 3, 1, 0, 0);
`endif
        push(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        push(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front());
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_mid_game[%0d]: got %p want %p", i, got, want);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back;
        obs_t got, want;
        int   i = 0;
        push(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
        push(0, 0, 1, 0, 0, 3, 3, 0, 1, 0);
        push(0, 0, 0, 0, 0, 2, 3, 1, 0, 0);
        push(0, 0, 1, 0, 0, 4, 3, 1, 1, 0);
        push(0, 0, 0, 0, 1, 7, 3, 1, 0, 0);
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front());
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %p want %p", i, got, want);
            end
            i++;
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.move_valid  = 1'b0;
        bus.win_detect  = 1'b0;
        bus.draw_detect = 1'b0;
        test_reset();
        test_start_countdown();
        test_move_tick_collision();
        test_check_outcomes();
        test_timeout();
        test_ignored_inputs();
        test_reset_mid_game();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
